task_reg_file: RTL and testbench
================================

# task_reg_file

Parametrised multi-task register file for the execution core, successor to the two-bank, 16×16 design. It holds `TASKS` independent banks of `REGS` registers, each `DATA_W` bits, with two asynchronous read ports, one synchronous write port and same-cycle write-to-read bypass. It adds three things the two-bank design lacks:
- a zeroing sweep after reset;
- a per-task clear sequencer for context teardown;
- a per-register pending scoreboard that the issue stage uses for hazard checks.

## Interface
Parameters:
- `DATA_W`, 16, register width in bits (≥1)
- `REGS`, 16, registers per task; power of two, ≥2
- `TASKS`, 4, task banks; power of two, ≥2
- Derived: `RW` = log2(`REGS`), `TW` = log2(`TASKS`)

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `ws`  in  1  write strobe
- `w_ts`  in  `TW`  write task select
- `rd_sel`  in  `RW`  destination register
- `rd_val`  in  `DATA_W`  destination value
- `r_ts`  in  `TW`  read task select
- `ra_sel`, `rb_sel`  in  `RW`  read port A/B register select
- `ra_val`, `rb_val`  out  `DATA_W`  read port A/B data (combinational)
- `ra_rdy`, `rb_rdy`  out  1  selected register has no pending write
- `pend_set`  in  1  mark entry {`pend_ts`,`pend_sel`} pending
- `pend_ts`  in  `TW`  pending-mark task
- `pend_sel`  in  `RW`  pending-mark register
- `clr_req`  in  1  request zeroing of task `clr_ts`
- `clr_ts`  in  `TW`  task to clear
- `busy`  out  1  sweep in progress; external writes and clear requests are ignored

## Operation
- Storage is `TASKS`×`REGS` words, addressed {task, reg}. Pending bits use the same array shape.
- FSM states are INIT, IDLE and CLEAR. The sweep counter `cnt` is `TW`+`RW` bits wide.
- **INIT.** Entered on any cycle with `rst_n`=0, including mid-CLEAR; all pending bits are cleared.
  - One entry per cycle, `cnt` = 0 … `TASKS`·`REGS`−1, the entry is written with zero.
  - At terminal count, go to IDLE.
  - All reads return 0 and `ra_rdy`=`rb_rdy`=0.
- **IDLE.**
  - `ws`=1 writes `rd_val` to {`w_ts`,`rd_sel`} and clears that entry's pending bit.
  - `clr_req`=1 latches `clr_ts`, clears all `REGS` pending bits of that task and goes to CLEAR. A write in the same cycle is still performed.
- **CLEAR.**
  - One register of the latched task is zeroed per cycle, `cnt` = 0 … `REGS`−1, then the FSM returns to IDLE.
  - External `ws` and `clr_req` are ignored (dropped, not queued).
  - Reads of the latched task return 0. Reads of other tasks behave normally.
- **Bypass.** When a write is accepted this cycle, `w_ts`==`r_ts` and `rd_sel`==`ra_sel`, `ra_val`=`rd_val` and `ra_rdy`=1. The same rule applies to port B.
- **Scoreboard.**
  - `ra_rdy` = NOT pend[{`r_ts`,`ra_sel`}], overridden by bypass as above.
  - `pend_set` is honoured in every state except INIT.
  - If an accepted write and `pend_set` target the same entry in the same cycle, set wins and the bit ends at 1.
  - A `pend_set` landing in CLEAR on the task being cleared is kept.
- Reads never alter state. Out-of-range selects cannot occur because widths are exact.

## Timing
- Reset values: FSM=INIT, `cnt`=0, `busy`=1, `ra_val`=`rb_val`=0, `ra_rdy`=`rb_rdy`=0, all pending bits 0.
- `busy` stays 1 for `TASKS`·`REGS` cycles after the first cycle with `rst_n`=1 (64 with defaults), then drops to 0.
- Write latency: 0 cycles through bypass, 1 cycle through the array.
- `clr_req` is sampled only when `busy`=0. `busy` rises on the next edge and stays high exactly `REGS` cycles.
- A pending-bit update (`pend_set`, write-clear, task clear) is visible on `ra_rdy`/`rb_rdy` the cycle after the edge.

## Test plan
- **Reset sweep:** hold `rst_n`=0 for 2 cycles, then release → `busy`=1 for exactly 64 cycles; afterwards every {t,r} reads 0 with rdy=1.
- **Write/bypass:** write 0xBEEF to {2,5} while reading `ra_sel`=5, `r_ts`=2 in the same cycle → `ra_val`=0xBEEF and `ra_rdy`=1 that cycle; the next cycle, with `ws`=0, the read returns 0xBEEF.
- **Task isolation:** write 0x1111 to {0,3} and 0x2222 to {1,3} → reads of 3 return 0x1111 under `r_ts`=0 and 0x2222 under `r_ts`=1.
- **Scoreboard:**
  - `pend_set` {1,7} → `rb_rdy`=0 on the next cycle for `rb_sel`=7, `r_ts`=1.
  - Write 0x00AA to {1,7} → `rb_rdy`=1 that same cycle through bypass, and 1 afterwards.
  - Simultaneous `pend_set` and write to {1,7} → bit stays 1.
- **Task clear:** fill task 3 with 0x5A5A and task 2 with 0x3C3C, then `clr_req` with `clr_ts`=3 → `busy` high 16 cycles; `ws` to {3,0} during the sweep is dropped; afterwards task 3 reads all 0 and task 2 still reads 0x3C3C.
- **Reset mid-clear:** assert `rst_n`=0 on the 5th CLEAR cycle → `busy` stays 1, a full 64-cycle INIT follows, and every entry of every task reads 0 afterwards.

Source files
------------

// File: rtl/task_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : task_reg_file
//  Description : Multi-task register file. TASKS banks of REGS x DATA_W words,
//                two combinational read ports with write bypass, one write
//                port, a zeroing sweep after reset, a per-task clear
//                sequencer and a per-register pending scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module task_reg_file #(
  parameter int DATA_W = 16,
  parameter int REGS   = 16,
  parameter int TASKS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ws,
  input  logic [$clog2(TASKS)-1:0] w_ts,
  input  logic [$clog2(REGS)-1:0]  rd_sel,
  input  logic [DATA_W-1:0]        rd_val,
  input  logic [$clog2(TASKS)-1:0] r_ts,
  input  logic [$clog2(REGS)-1:0]  ra_sel,
  input  logic [$clog2(REGS)-1:0]  rb_sel,
  output logic [DATA_W-1:0]        ra_val,
  output logic [DATA_W-1:0]        rb_val,
  output logic                     ra_rdy,
  output logic                     rb_rdy,
  input  logic                     pend_set,
  input  logic [$clog2(TASKS)-1:0] pend_ts,
  input  logic [$clog2(REGS)-1:0]  pend_sel,
  input  logic                     clr_req,
  input  logic [$clog2(TASKS)-1:0] clr_ts,
  output logic                     busy
);

  localparam int RW    = $clog2(REGS);
  localparam int TW    = $clog2(TASKS);
  localparam int AW    = RW + TW;
  localparam int DEPTH = TASKS * REGS;

  localparam logic [AW-1:0] c_last_entry = AW'(DEPTH - 1);
  localparam logic [RW-1:0] c_last_reg   = RW'(REGS - 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t              state_q;
  logic [AW-1:0]       cnt_q;
  logic [TW-1:0]       clr_ts_q;
  logic                busy_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]    pend_q;

  logic                w_we;
  logic [AW-1:0]       w_waddr;
  logic [AW-1:0]       w_ra_addr;
  logic [AW-1:0]       w_rb_addr;
  logic [AW-1:0]       w_pend_addr;
  logic                w_byp_a;
  logic                w_byp_b;
  logic                w_blank;

  // External writes only land while idle; the sweeps own the array otherwise.
  assign w_we        = ws & (state_q == S_IDLE);
  assign w_waddr     = {w_ts, rd_sel};
  assign w_ra_addr   = {r_ts, ra_sel};
  assign w_rb_addr   = {r_ts, rb_sel};
  assign w_pend_addr = {pend_ts, pend_sel};
  assign w_byp_a     = w_we & (w_ts == r_ts) & (rd_sel == ra_sel);
  assign w_byp_b     = w_we & (w_ts == r_ts) & (rd_sel == rb_sel);
  // The bank being cleared reads as zero even before the sweep reaches it.
  assign w_blank     = (state_q == S_CLEAR) & (r_ts == clr_ts_q);
  assign busy        = busy_q;

  // Sequencer: reset sweep, idle, and per-task clear sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      clr_ts_q <= '0;
      busy_q   <= 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == c_last_entry) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        S_IDLE: begin
          if (clr_req) begin
            clr_ts_q <= clr_ts;
            state_q  <= S_CLEAR;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
          end
        end
        S_CLEAR: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q[RW-1:0] == c_last_reg) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= S_INIT;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Storage array: sweep zeroing has priority, otherwise the external write.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_INIT) begin
        mem_q[cnt_q] <= '0;
      end else if (state_q == S_CLEAR) begin
        mem_q[{clr_ts_q, cnt_q[RW-1:0]}] <= '0;
      end else if (w_we) begin
        mem_q[w_waddr] <= rd_val;
      end
    end
  end

  // Pending scoreboard: clears first, set last so a same-entry set wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else if (state_q != S_INIT) begin
      if ((state_q == S_IDLE) && clr_req) begin
        for (int r = 0; r < REGS; r++) begin
          pend_q[{clr_ts, RW'(r)}] <= 1'b0;
        end
      end
      if (w_we) begin
        pend_q[w_waddr] <= 1'b0;
      end
      if (pend_set) begin
        pend_q[w_pend_addr] <= 1'b1;
      end
    end
  end

  // Read ports: zero while sweeping after reset, bypass the accepted write.
  always_comb begin
    ra_val = '0;
    ra_rdy = 1'b0;
    rb_val = '0;
    rb_rdy = 1'b0;
    if (state_q != S_INIT) begin
      if (w_byp_a) begin
        ra_val = rd_val;
        ra_rdy = 1'b1;
      end else begin
        ra_val = w_blank ? '0 : mem_q[w_ra_addr];
        ra_rdy = ~pend_q[w_ra_addr];
      end
      if (w_byp_b) begin
        rb_val = rd_val;
        rb_rdy = 1'b1;
      end else begin
        rb_val = w_blank ? '0 : mem_q[w_rb_addr];
        rb_rdy = ~pend_q[w_rb_addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_task_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_task_reg_file
//  Description : Scoreboard bench for task_reg_file. A driver issues directed
//                and random stimulus and pushes the reference model's
//                expected read-port/busy values; a negedge monitor pops and
//                compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_task_reg_file;

  localparam int DATA_W = 16;
  localparam int REGS   = 16;
  localparam int TASKS  = 4;
  localparam int RW     = 4;
  localparam int TW     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              ws;
  logic [TW-1:0]     w_ts;
  logic [RW-1:0]     rd_sel;
  logic [DATA_W-1:0] rd_val;
  logic [TW-1:0]     r_ts;
  logic [RW-1:0]     ra_sel;
  logic [RW-1:0]     rb_sel;
  logic [DATA_W-1:0] ra_val;
  logic [DATA_W-1:0] rb_val;
  logic              ra_rdy;
  logic              rb_rdy;
  logic              pend_set;
  logic [TW-1:0]     pend_ts;
  logic [RW-1:0]     pend_sel;
  logic              clr_req;
  logic [TW-1:0]     clr_ts;
  logic              busy;

  task_reg_file #(.DATA_W(DATA_W), .REGS(REGS), .TASKS(TASKS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ws       (ws),
    .w_ts     (w_ts),
    .rd_sel   (rd_sel),
    .rd_val   (rd_val),
    .r_ts     (r_ts),
    .ra_sel   (ra_sel),
    .rb_sel   (rb_sel),
    .ra_val   (ra_val),
    .rb_val   (rb_val),
    .ra_rdy   (ra_rdy),
    .rb_rdy   (rb_rdy),
    .pend_set (pend_set),
    .pend_ts  (pend_ts),
    .pend_sel (pend_sel),
    .clr_req  (clr_req),
    .clr_ts   (clr_ts),
    .busy     (busy)
  );

  // Reference model: contents, pending flags and remaining busy cycles.
  logic [DATA_W-1:0] m_mem  [TASKS][REGS];
  bit                m_pend [TASKS][REGS];
  int                init_left  = 0;
  int                clear_left = 0;
  bit                m_valid    = 1'b0;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic              ar;
    logic [DATA_W-1:0] b;
    logic              br;
    logic              bsy;
  } obs_t;

  obs_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic obs_t predict();
    obs_t e;
    bit   acc;
    e.bsy = (init_left > 0) || (clear_left > 0);
    if (init_left > 0) begin
      e.a = '0; e.ar = 1'b0; e.b = '0; e.br = 1'b0;
    end else begin
      acc = ws && !e.bsy;
      if (acc && w_ts == r_ts && rd_sel == ra_sel) begin
        e.a = rd_val; e.ar = 1'b1;
      end else begin
        e.a = m_mem[r_ts][ra_sel]; e.ar = !m_pend[r_ts][ra_sel];
      end
      if (acc && w_ts == r_ts && rd_sel == rb_sel) begin
        e.b = rd_val; e.br = 1'b1;
      end else begin
        e.b = m_mem[r_ts][rb_sel]; e.br = !m_pend[r_ts][rb_sel];
      end
    end
    return e;
  endfunction

  // A cleared task is zeroed at once in the model: its reads are 0 for the
  // whole sweep and writes are dropped, so the end result is identical.
  task automatic model_edge();
    if (!rst_n) begin
      for (int t = 0; t < TASKS; t++)
        for (int r = 0; r < REGS; r++) begin
          m_mem[t][r]  = '0;
          m_pend[t][r] = 1'b0;
        end
      init_left  = TASKS * REGS;
      clear_left = 0;
      m_valid    = 1'b1;
    end else if (init_left > 0) begin
      init_left--;
    end else begin
      if (clear_left > 0) begin
        clear_left--;
      end else begin
        if (ws) begin
          m_mem[w_ts][rd_sel]  = rd_val;
          m_pend[w_ts][rd_sel] = 1'b0;
        end
        if (clr_req) begin
          for (int r = 0; r < REGS; r++) begin
            m_mem[clr_ts][r]  = '0;
            m_pend[clr_ts][r] = 1'b0;
          end
          clear_left = REGS;
        end
      end
      if (pend_set) m_pend[pend_ts][pend_sel] = 1'b1;
    end
  endtask

  task automatic tick();
    if (m_valid) exp_q.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    ws = 1'b0; pend_set = 1'b0; clr_req = 1'b0;
  endtask

  task automatic read_all();
    quiet();
    for (int t = 0; t < TASKS; t++)
      for (int r = 0; r < REGS; r++) begin
        r_ts   = TW'(t);
        ra_sel = RW'(r);
        rb_sel = RW'(REGS - 1 - r);
        tick();
      end
  endtask

  task automatic fill(input int t, input logic [DATA_W-1:0] v);
    quiet();
    for (int r = 0; r < REGS; r++) begin
      ws = 1'b1; w_ts = TW'(t); rd_sel = RW'(r); rd_val = v;
      r_ts = TW'(t); ra_sel = RW'(r); rb_sel = RW'(r + 1);
      tick();
    end
    quiet();
  endtask

  task automatic rand_inputs(input bit allow_reset);
    ws       = 1'($urandom_range(0, 1));
    w_ts     = TW'($urandom_range(0, TASKS - 1));
    rd_sel   = RW'($urandom_range(0, 3));
    rd_val   = DATA_W'($urandom);
    r_ts     = TW'($urandom_range(0, TASKS - 1));
    ra_sel   = RW'($urandom_range(0, 3));
    rb_sel   = RW'($urandom_range(0, REGS - 1));
    pend_set = ($urandom_range(0, 3) == 0);
    pend_ts  = TW'($urandom_range(0, TASKS - 1));
    pend_sel = RW'($urandom_range(0, 3));
    clr_req  = ($urandom_range(0, 29) == 0);
    clr_ts   = TW'($urandom_range(0, TASKS - 1));
    rst_n    = allow_reset ? ($urandom_range(0, 799) != 0) : 1'b1;
  endtask

  // Monitor: every cycle the DUT presents its read ports and busy flag.
  always @(negedge clk) begin
    obs_t e;
    obs_t got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {ra_val, ra_rdy, rb_val, rb_rdy, busy};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL port_check t=%0t got a=%h ar=%b b=%h br=%b busy=%b, expected a=%h ar=%b b=%h br=%b busy=%b",
                 $time, got.a, got.ar, got.b, got.br, got.bsy, e.a, e.ar, e.b, e.br, e.bsy);
      end
    end
  end

  initial begin
    rst_n = 1'b0; quiet();
    w_ts = '0; rd_sel = '0; rd_val = '0; r_ts = '0; ra_sel = '0; rb_sel = '0;
    pend_ts = '0; pend_sel = '0; clr_ts = '0;

    // Reset sweep: two reset cycles, then INIT with ignored traffic.
    tick(); tick();
    rst_n = 1'b1;
    repeat (66) begin
      rand_inputs(1'b0);
      tick();
    end
    read_all();

    // Write with same-cycle bypass, then read through the array.
    ws = 1'b1; w_ts = 2'd2; rd_sel = 4'd5; rd_val = 16'hBEEF;
    r_ts = 2'd2; ra_sel = 4'd5; rb_sel = 4'd4;
    tick();
    ws = 1'b0;
    tick();

    // Task isolation on register 3.
    ws = 1'b1; w_ts = 2'd0; rd_sel = 4'd3; rd_val = 16'h1111; tick();
    w_ts = 2'd1; rd_val = 16'h2222; tick();
    ws = 1'b0; ra_sel = 4'd3; rb_sel = 4'd3;
    r_ts = 2'd0; tick();
    r_ts = 2'd1; tick();

    // Scoreboard: set, write-clear with bypass, simultaneous set and write.
    pend_set = 1'b1; pend_ts = 2'd1; pend_sel = 4'd7; r_ts = 2'd1; rb_sel = 4'd7;
    tick();
    pend_set = 1'b0; tick();
    ws = 1'b1; w_ts = 2'd1; rd_sel = 4'd7; rd_val = 16'h00AA; tick();
    ws = 1'b0; tick();
    ws = 1'b1; pend_set = 1'b1; rd_val = 16'h0055; tick();
    quiet(); tick(); tick();

    // Task clear of bank 3 with dropped writes and clear requests.
    fill(3, 16'h5A5A);
    fill(2, 16'h3C3C);
    clr_req = 1'b1; clr_ts = 2'd3; r_ts = 2'd3; ra_sel = 4'd0; rb_sel = 4'd9;
    tick();
    ws = 1'b1; w_ts = 2'd3; rd_sel = 4'd0; rd_val = 16'hFFFF;
    clr_ts = 2'd2;
    repeat (16) tick();
    quiet();
    read_all();

    // Reset asserted on the fifth cycle of a clear of bank 2.
    clr_req = 1'b1; clr_ts = 2'd2; r_ts = 2'd2;
    tick();
    clr_req = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    repeat (64) tick();
    read_all();

    // Random traffic with occasional clears and resets.
    repeat (3000) begin
      rand_inputs(1'b1);
      tick();
    end
    rst_n = 1'b1; quiet();
    repeat (80) tick();
    read_all();

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_check got %0d outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
